// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, line levels and parity helper for the parity frame receiver
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Parity bit a transmitter appends to word; odd selects odd parity sense.
   function automatic logic parity_of(input logic [31:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/parity_bit_acc.sv
// rtl/parity_bit_acc.sv - registered 1-bit XOR accumulator with clear-to-value and enable
module parity_bit_acc (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic clr_val,
   input  logic en,
   input  logic bit_in,
   output logic acc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= 1'b0;
      end else if (clr) begin
         acc <= clr_val;
      end else if (en) begin
         acc <= acc ^ bit_in;
      end
   end

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - bit-serial frame receiver: start, DATA_W data bits LSB first, parity, stop
module parity_frame_rx
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ODD    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   // Seeding with the parity of an empty word makes a matching frame leave acc at 0.
   localparam logic             ACC_SEED = parity_of(32'd0, 1'(ODD));

   rx_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              acc;

   logic start, shift, acc_en, done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift     = 1'b0;
      acc_en    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (din_valid && din == START_BIT) begin
               start     = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (din_valid) begin
               shift  = 1'b1;
               acc_en = 1'b1;
               if (cnt == LAST_BIT) begin
                  state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (din_valid) begin
               acc_en    = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (din_valid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   parity_bit_acc u_acc (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .clr_val (ACC_SEED),
      .en      (acc_en),
      .bit_in  (din),
      .acc     (acc)
   );

   // The counter parks on the last bit index rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (start) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (shift) begin
         shreg[cnt] <= din;
         if (cnt != LAST_BIT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid <= done;
         if (done) begin
            data_out   <= shreg;
            parity_err <= acc;
            frame_err  <= (din != STOP_BIT);
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver that checks the parity bit computed by the XOR parity generator. It accepts a bit-serial frame: start bit, DATA_W data bits LSB first, one parity bit, one stop bit. It runs an XOR accumulation over the received bits, reassembles the data word, and flags parity and framing errors. It sits at the receive end of any serial link whose transmit side builds its parity bit from an XOR tree.

## Interface
Parameters:
- DATA_W, 8, number of data bits per frame (1..32)
- ODD, 0, parity sense. 0 means even parity, so the XOR of data bits and parity bit is 0. 1 means odd parity, so that XOR is 1.

Ports:
- clk  input  1  single clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- din  input  1  serial line bit; idles at 1
- din_valid  input  1  din is sampled only on cycles where this is 1
- data_out  output  DATA_W  last completed frame's data word
- valid  output  1  one-cycle pulse when a frame completes
- parity_err  output  1  parity result of the last completed frame; 1 means mismatch
- frame_err  output  1  stop bit of the last completed frame was 0
- busy  output  1  high while the receiver is in a non-IDLE state

## Operation
- FSM states:
  - IDLE: waits for a start bit, which is din=0 with din_valid=1. din=1 with din_valid is ignored. Start bit leads to DATA, clears the bit counter and clears the accumulator to ODD.
  - DATA: each valid bit shifts into the data shift register at bit position cnt, LSB first. Each valid bit also updates acc ^= din. When cnt reaches DATA_W-1 on a valid bit, the FSM moves to PARITY.
  - PARITY: a valid bit updates acc ^= din and moves to STOP.
  - STOP: a valid bit completes the frame and returns to IDLE.
- On frame completion:
  - data_out takes the shift register value.
  - parity_err takes acc.
  - frame_err takes !din.
  - valid pulses for exactly one cycle.
- A frame with errors still pulses valid and updates data_out.
- data_out, parity_err and frame_err hold their values until the next frame completes.
- Cycles with din_valid=0 leave all state unchanged. Gaps of any length are allowed at any point in a frame.
- busy = (state != IDLE), decoded from registered state.
- Bit counter width is $clog2(DATA_W), with a minimum of 1. The counter never wraps inside a frame.

## Timing
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
- All outputs are registered.
- valid rises on the clock edge that samples the stop bit and is visible in the following cycle.
- Minimum frame length is DATA_W+3 valid cycles. Back-to-back frames are supported:
  - A start bit may be presented on the cycle immediately after the stop bit, i.e. while valid is high.
  - That start bit is accepted from IDLE.
- rst asserted mid-frame:
  - The next edge aborts the frame and returns to IDLE.
  - valid does not pulse.
  - All outputs return to their reset values.
- rst together with din_valid: rst wins and the bit is discarded.
- After a frame_err, the receiver still returns to IDLE. It does not hunt for the next edge; it waits for din=0.

## Structure
- Shared package parity_pkg holds:
  - the state typedef (IDLE, DATA, PARITY, STOP)
  - the stop-bit level constant (1) and start-bit level constant (0)
  - a function parity_of(word, odd) used by both RTL and the bench scoreboard
- One sub-module is natural: parity_bit_acc. It is a 1-bit XOR accumulator with clear-to-value and enable inputs, and it is the registered counterpart of the XOR generator.
- The FSM, counter and shift register live in parity_frame_rx.

## Test plan
All scenarios use DATA_W=8 and ODD=0 unless stated otherwise.
- Clean frame. Stimulus: din sequence 0, 1,0,1,0,0,1,0,1, 0, 1, with din_valid held high (frame 0xA5, parity 0). Required: data_out=0xA5, valid high exactly 1 cycle, parity_err=0, frame_err=0.
- Parity error. Stimulus: frame 0x01 sent with parity bit 0. Required: data_out=0x01, valid pulses, parity_err=1, frame_err=0.
- Framing error. Stimulus: frame 0x3C with parity 0 and stop bit 0. Required: data_out=0x3C, frame_err=1, parity_err=0. The receiver accepts a following clean 0x5A frame correctly.
- Gaps and odd parity. Stimulus: ODD=1, frame 0x00 with parity 1, din_valid low for 3 cycles between every bit. Required: data_out=0x00, parity_err=0, busy high throughout the frame, valid pulses once.
- Back-to-back plus reset. Stimulus, in order:
  - 0xFF then 0x80, with no idle cycle between them. Required: two valid pulses, DATA_W+3 cycles apart.
  - rst asserted after the 4th data bit of a third frame. Required: no valid pulse, outputs all zero, busy=0 on the next cycle.
